// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: one shared memory port, one instruction in flight,
// FETCH/DECODE/EXEC/MEM_RD/MEM_WR/WB sequencing with an absorbing HALT on illegal opcodes.
module mips_multicycle_core #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = 'h00400000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstb,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_wdata,
    output logic             mem_rd_ena,
    output logic             mem_wr_ena,
    input  logic [N-1:0]     mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pc, a, b, alu_out, mdr, alu_y, simm, wb_data;
    logic [31:0]    ir;
    logic [N-1:0]   rf [32];
    logic [5:0]     op, funct;
    logic [4:0]     rs, rt, rd, dst;
    logic           is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal, retire;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign simm  = {{(N-16){ir[15]}}, ir[15:0]};

    always_comb begin
        is_r    = (op == 6'd0) && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                                   funct == 6'd37 || funct == 6'd42);
        is_addi = (op == 6'd8);
        is_lw   = (op == 6'd35);
        is_sw   = (op == 6'd43);
        is_beq  = (op == 6'd4);
        is_j    = (op == 6'd2);
        legal   = is_r || is_addi || is_lw || is_sw || is_beq || is_j;
        dst     = is_r ? rd : rt;
        wb_data = is_lw ? mdr : alu_out;
    end

    // Non-R-type paths (addi, lw/sw address) all reduce to A + simm.
    always_comb begin
        alu_y = a + simm;
        if (is_r) begin
            case (funct)
                6'd34:   alu_y = a - b;
                6'd36:   alu_y = a & b;
                6'd37:   alu_y = a | b;
                6'd42:   alu_y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
                default: alu_y = a + b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) state <= S_FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!legal) state_nxt = S_HALT;
                else if (is_j) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_lw)      state_nxt = S_MEM_RD;
                else if (is_sw) state_nxt = S_MEM_WR;
                else if (is_beq) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else state_nxt = S_WB;
            end
            S_MEM_RD: if (mem_ready) state_nxt = S_WB;
            S_MEM_WR: if (mem_ready) begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // Memory handshake: a request (rd_ena or wr_ena) stays asserted with stable
    // addr/wdata until the cycle mem_ready=1 is seen at a rising edge; mem_ready
    // outside a request is ignored. Reset drops any request in the same cycle.
    always_comb begin
        mem_rd_ena = !rstb && (state == S_FETCH || state == S_MEM_RD);
        mem_wr_ena = !rstb && (state == S_MEM_WR);
        mem_addr   = (state == S_MEM_RD || state == S_MEM_WR) ? alu_out : pc;
        mem_wdata  = (state == S_MEM_WR) ? b : '0;
        halted     = (state == S_HALT);
        dbg_state  = state;
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            retired <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (retire) retired <= retired + 1'b1;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata[31:0];
                    pc <= pc + N'(4);
                end
                S_DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                    if (is_j) pc <= {pc[N-1:28], ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    if (is_beq && a == b) pc <= pc + (simm << 2);
                end
                S_MEM_RD: if (mem_ready) mdr <= mem_rdata;
                S_WB:     if (dst != 5'd0) rf[dst] <= wb_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: word memory model with programmable
// ready latency, store scoreboard, and hand-computed register/PC/counter checks.
module tb_mips_multicycle_core;
  localparam int          N        = 32;
  localparam int          SB_W     = 64;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [2:0]  ST_FETCH  = 3'd0;
  localparam logic [2:0]  ST_MEM_RD = 3'd3;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic [N-1:0]  mem_addr, mem_wdata;
  logic          mem_rd_ena, mem_wr_ena;
  logic [N-1:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          halted;
  logic [15:0]   retired;
  logic [2:0]    dbg_state;

  logic [31:0]   imem [0:63];
  logic [31:0]   dmem [0:63];
  logic [31:0]   ioff;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp_e;

  int ready_lat  = 0;
  bit stall_data = 1'b0;
  bit answer;
  int wait_cnt   = 0;
  int wr_cycles  = 0;
  int halt_reqs  = 0;
  int n_checks   = 0;
  int n_bad      = 0;

  // clock / reset
  always #5 clk = ~clk;

  mips_multicycle_core #(.N(N), .RESET_PC(RESET_PC), .CNT_W(16)) dut (
    .clk(clk), .rstb(rstb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_ena(mem_rd_ena), .mem_wr_ena(mem_wr_ena),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  assign ioff = mem_addr - RESET_PC;

  // memory responder + store scoreboard
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      wr_cycles = 0;
    end
    if (halted && (mem_rd_ena || mem_wr_ena)) halt_reqs++;
    if (mem_wr_ena) wr_cycles++;
    if (mem_rd_ena || mem_wr_ena) begin
      answer = !(stall_data && mem_addr < RESET_PC) && (wait_cnt >= ready_lat);
      if (answer) begin
        mem_ready = 1'b1;
        if (mem_rd_ena) begin
          mem_rdata = (mem_addr >= RESET_PC) ? imem[ioff[7:2]] : dmem[mem_addr[7:2]];
        end else begin
          dmem[mem_addr[7:2]] = mem_wdata;
          check("store_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("store_addr_data", {mem_addr, mem_wdata}, exp_e);
          end
          check("store_wr_cycles", wr_cycles, ready_lat + 1);
        end
      end else if (!(stall_data && mem_addr < RESET_PC)) begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b1;
    step(2);
    rstb = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'hFC00_0000;
      dmem[i] = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // single addi after reset, immediate memory
    clear_mem();
    imem[0] = 32'h2001_0005;
    ready_lat = 0;
    rstb = 1'b1;
    step(2);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_rd_ena", mem_rd_ena, 0);
    check("rst_wr_ena", mem_wr_ena, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, ST_FETCH);
    rstb = 1'b0;
    #1;
    check("fetch_addr", mem_addr, RESET_PC);
    check("fetch_rd_ena", mem_rd_ena, 1);
    step(4);
    check("addi_retired", retired, 1);
    check("addi_next_pc", mem_addr, 32'h0040_0004);
    check("addi_rf1", dut.rf[1], 5);

    // ALU mix, branches, sw/lw with 3-cycle ready latency, then illegal 0x3F
    clear_mem();
    imem[0]  = 32'h2001_0007;  // addi $1,$0,7
    imem[1]  = 32'h2002_FFFD;  // addi $2,$0,-3
    imem[2]  = 32'h0022_1820;  // add  $3,$1,$2
    imem[3]  = 32'h0041_202A;  // slt  $4,$2,$1
    imem[4]  = 32'h0022_3022;  // sub  $6,$1,$2
    imem[5]  = 32'h0022_3824;  // and  $7,$1,$2
    imem[6]  = 32'h0022_4025;  // or   $8,$1,$2
    imem[7]  = 32'h0022_482A;  // slt  $9,$1,$2
    imem[8]  = 32'h1022_0001;  // beq  $1,$2,+1 (not taken)
    imem[9]  = 32'h1000_0001;  // beq  $0,$0,+1 (skips illegal word)
    imem[10] = 32'hFC00_0000;
    imem[11] = 32'hAC03_0000;  // sw $3,0
    imem[12] = 32'hAC04_0004;  // sw $4,4
    imem[13] = 32'hAC06_000C;  // sw $6,12
    imem[14] = 32'hAC07_0010;  // sw $7,16
    imem[15] = 32'hAC08_0014;  // sw $8,20
    imem[16] = 32'hAC09_0018;  // sw $9,24
    imem[17] = 32'hAC01_0008;  // sw $1,8
    imem[18] = 32'h8C05_0008;  // lw $5,8
    imem[19] = 32'hAC05_001C;  // sw $5,28
    imem[20] = 32'h2000_0009;  // addi $0,$0,9
    imem[21] = 32'hAC00_0020;  // sw $0,32
    exp_q.push_back({32'd0,  32'd4});
    exp_q.push_back({32'd4,  32'd1});
    exp_q.push_back({32'd12, 32'd10});
    exp_q.push_back({32'd16, 32'd5});
    exp_q.push_back({32'd20, 32'hFFFF_FFFF});
    exp_q.push_back({32'd24, 32'd0});
    exp_q.push_back({32'd8,  32'd7});
    exp_q.push_back({32'd28, 32'd7});
    exp_q.push_back({32'd32, 32'd0});
    ready_lat = 3;
    do_reset();
    for (int i = 0; i < 3000 && !halted; i++) step(1);
    check("prog_halted", halted, 1);
    check("sb_drained", exp_q.size(), 0);
    check("prog_retired", retired, 21);
    check("prog_rf3", dut.rf[3], 4);
    check("prog_rf4", dut.rf[4], 1);
    check("prog_rf5", dut.rf[5], 7);
    check("prog_rf0", dut.rf[0], 0);
    halt_reqs = 0;
    step(20);
    check("halt_retired", retired, 21);
    check("halt_reqs", halt_reqs, 0);
    check("halt_rd_ena", mem_rd_ena, 0);
    check("halt_sticky", halted, 1);
    rstb = 1'b1;
    step(1);
    rstb = 1'b0;
    #1;
    check("unhalt_flag", halted, 0);
    check("unhalt_pc", mem_addr, RESET_PC);
    check("unhalt_retired", retired, 0);

    // beq -1 loop at 0x00400010 reached by j
    clear_mem();
    imem[0] = 32'h0810_0004;   // j 0x0100004
    imem[4] = 32'h1000_FFFF;   // beq $0,$0,-1
    ready_lat = 0;
    do_reset();
    step(2);
    check("j_target", mem_addr, 32'h0040_0010);
    check("j_retired", retired, 1);
    for (int k = 0; k < 3; k++) begin
      step(3);
      check("beq_loop_pc", mem_addr, 32'h0040_0010);
      check("beq_loop_retired", retired, 2 + k);
    end

    // j 0x0100000 -> 0x00400000
    clear_mem();
    imem[0] = 32'h0810_0000;
    do_reset();
    step(2);
    check("j_self_pc", mem_addr, RESET_PC);
    check("j_self_retired", retired, 1);

    // reset while lw waits in MEM_RD
    clear_mem();
    imem[0] = 32'h8C05_0008;   // lw $5,8
    dmem[2] = 32'h0000_1234;
    stall_data = 1'b1;
    do_reset();
    step(3);
    check("lw_wait_state", dbg_state, ST_MEM_RD);
    check("lw_wait_addr", mem_addr, 32'd8);
    check("lw_wait_rd_ena", mem_rd_ena, 1);
    step(2);
    check("lw_still_waiting", dbg_state, ST_MEM_RD);
    rstb = 1'b1;
    #1;
    check("abort_rd_ena", mem_rd_ena, 0);
    step(1);
    rstb = 1'b0;
    #1;
    check("abort_state", dbg_state, ST_FETCH);
    check("abort_pc", mem_addr, RESET_PC);
    check("abort_rf5", dut.rf[5], 0);
    check("abort_retired", retired, 0);
    stall_data = 1'b0;

    // R-type with unsupported funct halts without retiring
    clear_mem();
    imem[0] = 32'h0000_0000;
    do_reset();
    step(2);
    check("bad_funct_halted", halted, 1);
    check("bad_funct_retired", retired, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
